// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Load/store request and response bundle between a processor
//                (master) and the mem_responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_ls;
    logic        req_sext;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_ls, req_sext,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_ls, req_sext,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Single-outstanding load/store memory with programmable wait
//                states. MEM_RESPONDER_ALIGN_CHECK_EN enables misalign errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_responder_if.slave bus
);
    localparam int c_AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state, w_stateNext;
    logic [3:0]      r_cnt, w_cntNext;
    logic            r_ready;
    logic            w_accept, w_commit;

    logic            r_write;
    logic [c_AW+1:0] r_addr;
    logic [31:0]     r_wdata;
    logic [1:0]      r_ls;
    logic            r_sext;

    logic            r_respValid;
    logic [31:0]     r_respRdata;
    logic            r_respErr;

    logic [31:0]     r_mem [DEPTH_WORDS];

    // WAIT lasts WAIT_CYCLES+1 cycles so the response lands WAIT_CYCLES+1
    // edges after acceptance, including the zero-wait case.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ready && bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_stateNext = WAIT;
                    w_cntNext   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_commit    = 1'b1;
                    w_stateNext = RESP;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            RESP:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Datapath on the latched request
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_word, w_shifted, w_lane, w_merged, w_load;
    logic [1:0]      w_off;
    logic [3:0]      w_byteEn;
    logic            w_isWord, w_isHalf, w_misaligned;

    assign w_idx    = r_addr[c_AW+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_isWord = (r_ls == 2'b00) || (r_ls == 2'b11);
    assign w_isHalf = (r_ls == 2'b01);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign w_off        = r_addr[1:0];
    assign w_misaligned = (w_isWord && (r_addr[1:0] != 2'b00)) ||
                          (w_isHalf && r_addr[0]);
`else
    assign w_off        = w_isWord ? 2'b00 : (w_isHalf ? {r_addr[1], 1'b0} : r_addr[1:0]);
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        w_byteEn = 4'b1111;
        w_lane   = r_wdata;
        if (w_isHalf) begin
            w_byteEn = w_off[1] ? 4'b1100 : 4'b0011;
            w_lane   = {2{r_wdata[15:0]}};
        end else if (!w_isWord) begin
            w_byteEn = 4'b0001 << w_off;
            w_lane   = {4{r_wdata[7:0]}};
        end
    end

    always_comb begin
        w_merged = w_word;
        for (int i = 0; i < 4; i++) begin
            if (w_byteEn[i]) w_merged[i*8 +: 8] = w_lane[i*8 +: 8];
        end
    end

    assign w_shifted = w_word >> {w_off, 3'b000};

    always_comb begin
        w_load = w_word;
        if (w_isHalf)
            w_load = {{16{r_sext & w_shifted[15]}}, w_shifted[15:0]};
        else if (!w_isWord)
            w_load = {{24{r_sext & w_shifted[7]}}, w_shifted[7:0]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_ready     <= 1'b0;
            r_respValid <= 1'b0;
            r_respRdata <= 32'd0;
            r_respErr   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_ready     <= (w_stateNext == IDLE);
            r_respValid <= w_commit;
            if (w_commit) begin
                r_respRdata <= (r_write || w_misaligned) ? 32'd0 : w_load;
                r_respErr   <= w_misaligned;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr[c_AW+1:0];
            r_wdata <= bus.req_wdata;
            r_ls    <= bus.req_ls;
            r_sext  <= bus.req_sext;
        end
    end

    // Storage is never cleared; reset only blocks an in-flight commit.
    always_ff @(posedge clk) begin
        if (reset && w_commit && r_write && !w_misaligned)
            r_mem[w_idx] <= w_merged;
    end

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_respValid;
    assign bus.resp_rdata = r_respRdata;
    assign bus.resp_err   = r_respErr;
endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Directed self-checking bench for mem_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH_WORDS = 256;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] ls, input logic sext);
        @(negedge clk);
        check("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_ls    = ls;
        bus.req_sext  = sext;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitResp(input string tag, input int startK,
                            output logic [31:0] rdata, output logic err);
        int k;
        k = startK;
        while (k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.resp_valid) break;
        end
        check({tag, "_latency"}, 32'(k), 32'(WAIT_CYCLES + 1));
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_hold"}, bus.resp_rdata, rdata);
    endtask

    task automatic doReq(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] ls, input logic sext,
                         input logic [31:0] expRdata, input logic expErr);
        logic [31:0] r;
        logic        e;
        issue(wr, addr, wdata, ls, sext);
        waitResp(tag, 0, r, e);
        check({tag, "_rdata"}, r, expRdata);
        check({tag, "_err"}, 32'(e), 32'(expErr));
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          pulses;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_ls    = 2'b00;
        bus.req_sext  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", 32'(bus.req_ready), 32'd1);

        doReq("st_word",   1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0,        1'b0);
        doReq("ld_word",   1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEADBEEF, 1'b0);
        doReq("ld_b_sx",   1'b0, 32'h13, 32'h0,        2'b10, 1'b1, 32'hFFFFFFDE, 1'b0);
        doReq("ld_b_zx",   1'b0, 32'h13, 32'h0,        2'b10, 1'b0, 32'h000000DE, 1'b0);
        doReq("ld_h_sx",   1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 32'hFFFFBEEF, 1'b0);
        doReq("ld_h_zx",   1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'h0000DEAD, 1'b0);
        doReq("ld_b1_sx",  1'b0, 32'h11, 32'h0,        2'b10, 1'b1, 32'hFFFFFFBE, 1'b0);
        doReq("st_byte",   1'b1, 32'h11, 32'h0000005A, 2'b10, 1'b0, 32'h0,        1'b0);
        doReq("ld_merge",  1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEAD5AEF, 1'b0);
        doReq("ld_ls11",   1'b0, 32'h10, 32'h0,        2'b11, 1'b1, 32'hDEAD5AEF, 1'b0);
        doReq("st_wrap",   1'b1, 32'h400, 32'h12345678, 2'b00, 1'b0, 32'h0,       1'b0);
        doReq("ld_wrap",   1'b0, 32'h0,  32'h0,        2'b00, 1'b0, 32'h12345678, 1'b0);
        doReq("ld_keep10", 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEAD5AEF, 1'b0);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        doReq("ld_misw",   1'b0, 32'h12, 32'h0,        2'b00, 1'b0, 32'h0,        1'b1);
        doReq("st_mish",   1'b1, 32'h11, 32'h00001234, 2'b01, 1'b0, 32'h0,        1'b1);
        doReq("ld_aftmis", 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEAD5AEF, 1'b0);
`else
        doReq("ld_misw",   1'b0, 32'h12, 32'h0,        2'b00, 1'b0, 32'hDEAD5AEF, 1'b0);
        doReq("st_mish",   1'b1, 32'h11, 32'h00001234, 2'b01, 1'b0, 32'h0,        1'b0);
        doReq("ld_aftmis", 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEAD1234, 1'b0);
`endif

        // A request held while busy must be ignored, not queued.
        issue(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_wdata = 32'hBADBAD00;
        @(posedge clk);
        #1;
        check("busy_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        waitResp("busy_ld", 1, r, e);
        check("busy_ld_rdata", r, 32'h12345678);
        doReq("busy_noq",  1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h12345678, 1'b0);

        // Reset asserted one edge before the store's commit edge.
        pulses = 0;
        issue(1'b1, 32'h0, 32'hCAFEF00D, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        pulses += int'(bus.resp_valid);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        pulses += int'(bus.resp_valid);
        check("midrst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        pulses += int'(bus.resp_valid);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        pulses += int'(bus.resp_valid);
        check("midrst_release_ready", 32'(bus.req_ready), 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
            pulses += int'(bus.resp_valid);
        end
        check("midrst_no_pulse", 32'(pulses), 32'd0);
        doReq("midrst_mem", 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h12345678, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
